// File: rtl/ct_spsram_taint_wrap_if.sv
// rtl/ct_spsram_taint_wrap_if.sv - access bus of the taint-shadowed single-port SRAM wrapper
interface ct_spsram_taint_wrap_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 128,
   parameter int WE_WIDTH   = 128
);
   logic                  CEN;
   logic                  CEN_t0;
   logic                  GWEN;
   logic                  GWEN_t0;
   logic [ADDR_WIDTH-1:0] A;
   logic [ADDR_WIDTH-1:0] A_t0;
   logic [DATA_WIDTH-1:0] D;
   logic [DATA_WIDTH-1:0] D_t0;
   logic [WE_WIDTH-1:0]   WEN;
   logic [WE_WIDTH-1:0]   WEN_t0;
   logic [DATA_WIDTH-1:0] Q;
   logic [DATA_WIDTH-1:0] Q_t0;
   logic                  init_done;
   logic                  poison;

   modport master (
      output CEN, CEN_t0, GWEN, GWEN_t0, A, A_t0, D, D_t0, WEN, WEN_t0,
      input  Q, Q_t0, init_done, poison
   );

   modport slave (
      input  CEN, CEN_t0, GWEN, GWEN_t0, A, A_t0, D, D_t0, WEN, WEN_t0,
      output Q, Q_t0, init_done, poison
   );
endinterface

// File: rtl/ct_spsram_taint_wrap.sv
// rtl/ct_spsram_taint_wrap.sv - single-port SRAM wrapper with per-bit taint shadow, poison flag and init sequencer
module ct_spsram_taint_wrap #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 128,
   parameter int WE_WIDTH   = 128,
   parameter int RD_LAT     = 1,
   parameter int INIT_DATA  = 0
) (
   input logic                    CLK,
   input logic                    cpurst_b,
   ct_spsram_taint_wrap_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int LANE  = DATA_WIDTH / WE_WIDTH;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic                  init_done_q;
   logic                  poison_q;

   logic [DATA_WIDTH-1:0] mem_data   [DEPTH];
   logic [DATA_WIDTH-1:0] mem_shadow [DEPTH];

   logic [DATA_WIDTH-1:0] rd_q;
   logic [DATA_WIDTH-1:0] rd_q_t0;

   logic run;
   logic ctl_taint;
   logic wr_req;
   logic rd_req;
   logic poison_set;

   // Decode the access type; a tainted address or control bit makes the target uncertain.
   always_comb begin
      run        = (state == ST_RUN);
      ctl_taint  = (|bus.A_t0) | bus.CEN_t0 | bus.GWEN_t0;
      wr_req     = run & ~bus.CEN & ~bus.GWEN;
      rd_req     = run & ~bus.CEN &  bus.GWEN;
      poison_set = run & (~bus.CEN | bus.CEN_t0) & (~bus.GWEN | bus.GWEN_t0) & ctl_taint;
   end

   // Init/run sequencer; also owns the sticky poison flag.
   always_ff @(posedge CLK or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state       <= ST_INIT;
         init_cnt    <= '0;
         init_done_q <= 1'b0;
         poison_q    <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               if (init_cnt == {ADDR_WIDTH{1'b1}}) begin
                  state       <= ST_RUN;
                  init_done_q <= 1'b1;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (poison_set)
                  poison_q <= 1'b1;
            end
            default: state <= ST_INIT;
         endcase
      end
   end

   // Array writes: init clears one entry per cycle, run-time writes are lane-masked.
   always_ff @(posedge CLK) begin
      if (state == ST_INIT) begin
         mem_shadow[init_cnt] <= '0;
         if (INIT_DATA != 0)
            mem_data[init_cnt] <= '0;
      end else if (wr_req) begin
         for (int i = 0; i < WE_WIDTH; i++) begin
            if (!bus.WEN[i])
               mem_data[bus.A][i*LANE +: LANE] <= bus.D[i*LANE +: LANE];
            // An uncertain lane enable means the stored bits may or may not have changed.
            if (bus.WEN_t0[i])
               mem_shadow[bus.A][i*LANE +: LANE] <= {LANE{1'b1}};
            else if (!bus.WEN[i])
               mem_shadow[bus.A][i*LANE +: LANE] <= bus.D_t0[i*LANE +: LANE];
         end
      end
   end

   // First read stage: load on a read, taint-out when an access might have happened.
   always_ff @(posedge CLK or negedge cpurst_b) begin
      if (!cpurst_b) begin
         rd_q    <= '0;
         rd_q_t0 <= '0;
      end else if (rd_req) begin
         rd_q    <= mem_data[bus.A];
         rd_q_t0 <= mem_shadow[bus.A] | {DATA_WIDTH{ctl_taint | poison_q}};
      end else if (run & bus.CEN & bus.CEN_t0) begin
         rd_q_t0 <= {DATA_WIDTH{1'b1}};
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic [DATA_WIDTH-1:0] out_q;
         logic [DATA_WIDTH-1:0] out_q_t0;

         // Extra output register; copies every cycle so reads stay fully pipelined.
         always_ff @(posedge CLK or negedge cpurst_b) begin
            if (!cpurst_b) begin
               out_q    <= '0;
               out_q_t0 <= '0;
            end else begin
               out_q    <= rd_q;
               out_q_t0 <= rd_q_t0;
            end
         end

         assign bus.Q    = out_q;
         assign bus.Q_t0 = out_q_t0;
      end else begin : g_lat1
         assign bus.Q    = rd_q;
         assign bus.Q_t0 = rd_q_t0;
      end
   endgenerate

   assign bus.init_done = init_done_q;
   assign bus.poison    = poison_q;
endmodule

// File: tb/tb_ct_spsram_taint_wrap.sv
// tb/tb_ct_spsram_taint_wrap.sv - directed bench for ct_spsram_taint_wrap at read latency 1 and 2
module tb_ct_spsram_taint_wrap;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cen, cen_t0, gwen, gwen_t0;
   logic [3:0]  a, a_t0, wen, wen_t0;
   logic [31:0] d, d_t0;
   int          checks = 0;
   int          errors = 0;

   ct_spsram_taint_wrap_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WE_WIDTH(4)) bus1 ();
   ct_spsram_taint_wrap_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WE_WIDTH(4)) bus2 ();

   assign bus1.CEN = cen;     assign bus2.CEN = cen;
   assign bus1.CEN_t0 = cen_t0; assign bus2.CEN_t0 = cen_t0;
   assign bus1.GWEN = gwen;   assign bus2.GWEN = gwen;
   assign bus1.GWEN_t0 = gwen_t0; assign bus2.GWEN_t0 = gwen_t0;
   assign bus1.A = a;         assign bus2.A = a;
   assign bus1.A_t0 = a_t0;   assign bus2.A_t0 = a_t0;
   assign bus1.D = d;         assign bus2.D = d;
   assign bus1.D_t0 = d_t0;   assign bus2.D_t0 = d_t0;
   assign bus1.WEN = wen;     assign bus2.WEN = wen;
   assign bus1.WEN_t0 = wen_t0; assign bus2.WEN_t0 = wen_t0;

   ct_spsram_taint_wrap #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WE_WIDTH(4), .RD_LAT(1), .INIT_DATA(1)) dut1 (
      .CLK(clk), .cpurst_b(rst_n), .bus(bus1)
   );
   ct_spsram_taint_wrap #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WE_WIDTH(4), .RD_LAT(2), .INIT_DATA(1)) dut2 (
      .CLK(clk), .cpurst_b(rst_n), .bus(bus2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cen = 1'b1; cen_t0 = 1'b0; gwen = 1'b1; gwen_t0 = 1'b0;
      a = '0; a_t0 = '0; d = '0; d_t0 = '0; wen = '1; wen_t0 = '0;
   endtask

   task automatic do_read(input logic [3:0] addr, input logic [3:0] at0);
      idle();
      cen = 1'b0; a = addr; a_t0 = at0;
   endtask

   task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [31:0] dt0,
                           input logic [3:0] w, input logic [3:0] wt0, input logic [3:0] at0);
      idle();
      cen = 1'b0; gwen = 1'b0; a = addr; a_t0 = at0; d = data; d_t0 = dt0; wen = w; wen_t0 = wt0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (bus1.Q !== 32'h0) begin errors++; $display("FAIL reset_q got %h exp 0", bus1.Q); end
      checks++; if (bus1.Q_t0 !== 32'h0) begin errors++; $display("FAIL reset_q_t0 got %h exp 0", bus1.Q_t0); end
      checks++; if (bus2.Q !== 32'h0) begin errors++; $display("FAIL reset_q_lat2 got %h exp 0", bus2.Q); end
      checks++; if (bus1.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b exp 0", bus1.init_done); end
      checks++; if (bus1.poison !== 1'b0) begin errors++; $display("FAIL reset_poison got %b exp 0", bus1.poison); end
   endtask

   task automatic test_init();
      do_read(4'd5, 4'd0);
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         checks++;
         if (bus1.init_done !== (k == 16)) begin
            errors++; $display("FAIL init_done_cycle%0d got %b exp %b", k, bus1.init_done, (k == 16));
         end
         checks++;
         if (bus1.Q !== 32'h0 || bus2.Q !== 32'h0) begin
            errors++; $display("FAIL init_q_hold cycle%0d got %h/%h exp 0", k, bus1.Q, bus2.Q);
         end
      end
      tick();
      checks++; if (bus1.Q !== 32'h0) begin errors++; $display("FAIL init_read5_q got %h exp 0", bus1.Q); end
      checks++; if (bus1.Q_t0 !== 32'h0) begin errors++; $display("FAIL init_read5_q_t0 got %h exp 0", bus1.Q_t0); end
      idle();
      tick();
   endtask

   task automatic test_lane_write();
      do_write(4'd3, 32'hAABBCCDD, 32'h000000F0, 4'b1010, 4'b0100, 4'd0);
      tick();
      checks++; if (bus1.Q !== 32'h0) begin errors++; $display("FAIL write_keeps_q got %h exp 0", bus1.Q); end
      do_read(4'd3, 4'd0);
      tick();
      checks++; if (bus1.Q !== 32'h00BB00DD) begin errors++; $display("FAIL lane_q got %h exp 00bb00dd", bus1.Q); end
      checks++; if (bus1.Q_t0 !== 32'h00FF00F0) begin errors++; $display("FAIL lane_q_t0 got %h exp 00ff00f0", bus1.Q_t0); end
      idle();
      tick();
      checks++; if (bus2.Q !== 32'h00BB00DD) begin errors++; $display("FAIL lane_q_lat2 got %h exp 00bb00dd", bus2.Q); end
      checks++; if (bus2.Q_t0 !== 32'h00FF00F0) begin errors++; $display("FAIL lane_q_t0_lat2 got %h exp 00ff00f0", bus2.Q_t0); end
   endtask

   task automatic test_addr_taint_read();
      do_read(4'd3, 4'd1);
      tick();
      checks++; if (bus1.Q !== 32'h00BB00DD) begin errors++; $display("FAIL ataint_q got %h exp 00bb00dd", bus1.Q); end
      checks++; if (bus1.Q_t0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL ataint_q_t0 got %h exp ffffffff", bus1.Q_t0); end
      checks++; if (bus1.poison !== 1'b0) begin errors++; $display("FAIL ataint_poison got %b exp 0", bus1.poison); end
      idle();
      tick();
   endtask

   task automatic test_back_to_back();
      do_write(4'd1, 32'h11111111, 32'h0, 4'b0000, 4'b0000, 4'd0);
      tick();
      do_write(4'd2, 32'h22222222, 32'h0, 4'b0000, 4'b0000, 4'd0);
      tick();
      do_read(4'd1, 4'd0);
      tick();
      checks++; if (bus1.Q !== 32'h11111111) begin errors++; $display("FAIL b2b_r1_lat1 got %h exp 11111111", bus1.Q); end
      checks++; if (bus2.Q !== 32'h00BB00DD) begin errors++; $display("FAIL b2b_r1_lat2_old got %h exp 00bb00dd", bus2.Q); end
      do_read(4'd2, 4'd0);
      tick();
      checks++; if (bus1.Q !== 32'h22222222) begin errors++; $display("FAIL b2b_r2_lat1 got %h exp 22222222", bus1.Q); end
      checks++; if (bus2.Q !== 32'h11111111) begin errors++; $display("FAIL b2b_r1_lat2 got %h exp 11111111", bus2.Q); end
      checks++; if (bus2.Q_t0 !== 32'h0) begin errors++; $display("FAIL b2b_r1_lat2_t0 got %h exp 0", bus2.Q_t0); end
      do_write(4'd1, 32'h99999999, 32'h0, 4'b0000, 4'b0000, 4'd0);
      tick();
      checks++; if (bus1.Q !== 32'h22222222) begin errors++; $display("FAIL b2b_wr_lat1 got %h exp 22222222", bus1.Q); end
      checks++; if (bus2.Q !== 32'h22222222) begin errors++; $display("FAIL b2b_r2_lat2 got %h exp 22222222", bus2.Q); end
      do_read(4'd1, 4'd0);
      tick();
      checks++; if (bus1.Q !== 32'h99999999) begin errors++; $display("FAIL b2b_new_lat1 got %h exp 99999999", bus1.Q); end
      idle();
      tick();
      checks++; if (bus2.Q !== 32'h99999999) begin errors++; $display("FAIL b2b_new_lat2 got %h exp 99999999", bus2.Q); end
   endtask

   task automatic test_no_access_taint();
      idle();
      cen_t0 = 1'b1;
      tick();
      checks++; if (bus1.Q !== 32'h99999999) begin errors++; $display("FAIL noacc_q got %h exp 99999999", bus1.Q); end
      checks++; if (bus1.Q_t0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL noacc_q_t0 got %h exp ffffffff", bus1.Q_t0); end
      checks++; if (bus1.poison !== 1'b0) begin errors++; $display("FAIL noacc_poison got %b exp 0", bus1.poison); end
      idle();
      tick();
      checks++; if (bus1.Q_t0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL noacc_hold_t0 got %h exp ffffffff", bus1.Q_t0); end
      checks++; if (bus2.Q_t0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL noacc_lat2_t0 got %h exp ffffffff", bus2.Q_t0); end
   endtask

   task automatic test_poison();
      do_write(4'd4, 32'h12345678, 32'h0, 4'b0000, 4'b0000, 4'h2);
      tick();
      checks++; if (bus1.poison !== 1'b1) begin errors++; $display("FAIL poison_set got %b exp 1", bus1.poison); end
      checks++; if (bus2.poison !== 1'b1) begin errors++; $display("FAIL poison_set_lat2 got %b exp 1", bus2.poison); end
      do_read(4'd4, 4'd0);
      tick();
      checks++; if (bus1.Q !== 32'h12345678) begin errors++; $display("FAIL poison_rd_q got %h exp 12345678", bus1.Q); end
      checks++; if (bus1.Q_t0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL poison_rd_q_t0 got %h exp ffffffff", bus1.Q_t0); end
      do_read(4'd2, 4'd0);
      tick();
      checks++; if (bus1.Q_t0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL poison_rd2_q_t0 got %h exp ffffffff", bus1.Q_t0); end
      checks++; if (bus1.poison !== 1'b1) begin errors++; $display("FAIL poison_sticky got %b exp 1", bus1.poison); end
      idle();
      tick();
      checks++; if (bus2.Q !== 32'h22222222) begin errors++; $display("FAIL poison_lat2_q got %h exp 22222222", bus2.Q); end
      checks++; if (bus2.Q_t0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL poison_lat2_q_t0 got %h exp ffffffff", bus2.Q_t0); end
   endtask

   task automatic test_reset_mid_init();
      do_read(4'd1, 4'd0);
      rst_n = 1'b0;
      #1;
      checks++; if (bus1.poison !== 1'b0) begin errors++; $display("FAIL rst_poison_clear got %b exp 0", bus1.poison); end
      checks++; if (bus1.Q !== 32'h0 || bus2.Q_t0 !== 32'h0) begin errors++; $display("FAIL rst_q_clear got %h/%h exp 0", bus1.Q, bus2.Q_t0); end
      tick();
      rst_n = 1'b1;
      repeat (7) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         checks++;
         if (bus1.init_done !== (k == 16)) begin
            errors++; $display("FAIL reinit_done_cycle%0d got %b exp %b", k, bus1.init_done, (k == 16));
         end
      end
      tick();
      checks++; if (bus1.Q !== 32'h0) begin errors++; $display("FAIL reinit_data_clear got %h exp 0", bus1.Q); end
      checks++; if (bus1.Q_t0 !== 32'h0) begin errors++; $display("FAIL reinit_shadow_clear got %h exp 0", bus1.Q_t0); end
      checks++; if (bus1.poison !== 1'b0) begin errors++; $display("FAIL reinit_poison got %b exp 0", bus1.poison); end
      idle();
      tick();
   endtask

   initial begin
      test_reset();
      test_init();
      test_lane_write();
      test_addr_taint_read();
      test_back_to_back();
      test_no_access_taint();
      test_poison();
      test_reset_mid_init();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
